// File: rtl/multicycle_control.sv
// multicycle_control: main control unit of the multicycle MIPS core.
// Moore FSM driving every datapath control input, ALU decoder for R-type
// instructions, and a retired-instruction counter.
// Optional feature macro: MC_INTERRUPT_EN adds a one-cycle IRQ entry state
// taken at the end of a legal instruction while irq is high.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             irq,
  output logic             irqAck,
  output logic [1:0]       aluControl,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       PCSource,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             lorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             isBranch,
  output logic             isInterrupted,
  output logic             illegalOp,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       stateOut
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
`ifdef MC_INTERRUPT_EN
    ,
    S_IRQ    = 4'd13
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_end_target;
  logic             r_is_sw;
  logic             w_end;
  logic             w_funct_legal;
  logic [CNT_W-1:0] r_retired;

  // Only the four supported R-type functions are legal
  assign w_funct_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                         (funct == FN_AND) || (funct == FN_OR);

`ifdef MC_INTERRUPT_EN
  // A pending interrupt diverts the end of a legal instruction into IRQ
  assign w_end_target = irq ? S_IRQ : S_FETCH;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_end_target = S_FETCH;
`endif

  assign retired  = r_retired;
  assign stateOut = r_state;

  // State register; reset mid-instruction aborts straight to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember lw/sw choice in DECODE so op is not needed again in MEMADR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_sw <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_sw <= (op == OP_SW);
    end else begin
      r_is_sw <= r_is_sw;
    end
  end

  // Retired counter steps on the edge that completes a legal instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= {CNT_W{1'b0}};
    end else if (w_end) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_retired <= r_retired;
    end
  end

  // Next-state logic and Moore control outputs (funct also used in RTEXEC)
  always_comb begin
    w_next        = r_state;
    w_end         = 1'b0;
    irqAck        = 1'b0;
    aluControl    = ALU_ADD;
    aluSrcA       = 1'b0;
    aluSrcB       = 2'b00;
    PCSource      = 2'b00;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    lorD          = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    isBranch      = 1'b0;
    isInterrupted = 1'b0;
    illegalOp     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        aluSrcB = 2'b01;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct_legal) begin
              w_next = S_RTEXEC;
            end else begin
              illegalOp = 1'b1;
              w_next    = S_FETCH;
            end
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: begin
            illegalOp = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        lorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_end    = 1'b1;
        w_next   = w_end_target;
      end
      S_MEMWR: begin
        lorD     = 1'b1;
        MemWrite = 1'b1;
        w_end    = 1'b1;
        w_next   = w_end_target;
      end
      S_RTEXEC: begin
        aluSrcA = 1'b1;
        case (funct)
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          default: aluControl = ALU_ADD;
        endcase
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_end    = 1'b1;
        w_next   = w_end_target;
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        PCSource   = 2'b01;
        isBranch   = 1'b1;
        w_end      = 1'b1;
        w_next     = w_end_target;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_end    = 1'b1;
        w_next   = w_end_target;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        w_end    = 1'b1;
        w_next   = w_end_target;
      end
`ifdef MC_INTERRUPT_EN
      S_IRQ: begin
        isInterrupted = 1'b1;
        PCSource      = 2'b11;
        PCWrite       = 1'b1;
        irqAck        = 1'b1;
        w_next        = S_FETCH;
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
